// File: rtl/payload_sched.sv
// payload_sched: round-robin scheduler sharing one payload engine among NUM_SRC packet sources.
// Define PAYLOAD_SCHED_WATCHDOG_EN to bound WAIT_DONE with a WDOG_CYC-cycle watchdog.
module payload_sched #(
  parameter int NUM_SRC  = 4,
  parameter int SRC_W    = 2,
  parameter int MAX_LEN  = 2047,
  parameter int WDOG_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC-1:0]   src_eop,
  output logic [NUM_SRC-1:0]   src_grant,
  output logic [NUM_SRC-1:0]   src_trunc,
  output logic [7:0]           payload_out,
  output logic                 payload_valid,
  output logic                 start_of_packet,
  output logic                 end_of_packet,
  input  logic                 pmm_ready,
  input  logic                 eop_shift,
  input  logic                 filter_trigger,
  input  logic [10:0]          rule_id,
  output logic                 result_valid,
  output logic [SRC_W-1:0]     result_src,
  output logic [10:0]          result_rule,
  output logic [SRC_W-1:0]     cur_src,
  output logic                 busy,
  output logic                 wdog_timeout
);
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;
  state_t state;
  logic [SRC_W-1:0] rr_ptr, sel, nxt_ptr;
  logic [SRC_W:0] idx;
  logic [10:0] cnt;
  logic last, trunc;
`ifdef PAYLOAD_SCHED_WATCHDOG_EN
  logic [12:0] wcnt;
`endif
  if (NUM_SRC < 2 || NUM_SRC > 8 || MAX_LEN < 1 || MAX_LEN > 2047 || WDOG_CYC < 1 || WDOG_CYC > 8191) begin : g_param_check
    $error("payload_sched: parameter out of range");
  end
  // Scan from the farthest candidate down so the nearest requester at/after rr_ptr wins.
  always_comb begin
    sel = rr_ptr;
    idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (idx >= (SRC_W+1)'(NUM_SRC)) idx = idx - (SRC_W+1)'(NUM_SRC);
      if (src_req[idx[SRC_W-1:0]]) sel = idx[SRC_W-1:0];
    end
  end
  assign last    = src_eop[cur_src] || cnt == 11'(MAX_LEN - 1);
  assign trunc   = !src_eop[cur_src] && cnt == 11'(MAX_LEN - 1);
  assign nxt_ptr = (cur_src == SRC_W'(NUM_SRC - 1)) ? '0 : cur_src + 1'b1;
  assign busy    = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      cur_src         <= '0;
      cnt             <= '0;
      src_grant       <= '0;
      src_trunc       <= '0;
      payload_out     <= '0;
      payload_valid   <= 1'b0;
      start_of_packet <= 1'b0;
      end_of_packet   <= 1'b0;
      result_valid    <= 1'b0;
      result_src      <= '0;
      result_rule     <= '0;
      wdog_timeout    <= 1'b0;
`ifdef PAYLOAD_SCHED_WATCHDOG_EN
      wcnt            <= '0;
`endif
    end else begin
      payload_valid   <= 1'b0;
      start_of_packet <= 1'b0;
      end_of_packet   <= 1'b0;
      src_trunc       <= '0;
      wdog_timeout    <= 1'b0;
      result_valid    <= filter_trigger && state != IDLE;
      if (filter_trigger && state != IDLE) begin
        result_src  <= cur_src;
        result_rule <= rule_id;
      end
`ifdef PAYLOAD_SCHED_WATCHDOG_EN
      wcnt <= (state == WAIT_DONE) ? wcnt + 13'd1 : '0;
`endif
      case (state)
        IDLE: if (pmm_ready && |src_req) begin
          state     <= STREAM;
          cur_src   <= sel;
          src_grant <= NUM_SRC'(1) << sel;
          cnt       <= '0;
        end
        STREAM: if (src_valid[cur_src]) begin
          payload_out     <= src_data[8*cur_src +: 8];
          payload_valid   <= 1'b1;
          start_of_packet <= cnt == '0;
          cnt             <= cnt + 11'd1;
          if (last) begin
            end_of_packet <= 1'b1;
            src_grant     <= '0;
            src_trunc     <= trunc ? src_grant : '0;
            state         <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (eop_shift) begin
            rr_ptr <= nxt_ptr;
            state  <= IDLE;
          end
`ifdef PAYLOAD_SCHED_WATCHDOG_EN
          else if (wcnt == 13'(WDOG_CYC - 1)) begin
            wdog_timeout <= 1'b1;
            rr_ptr       <= nxt_ptr;
            state        <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_payload_sched.sv
// tb_payload_sched: directed + randomized checks of payload_sched against a packet-level reference model.
module tb_payload_sched;
  localparam int NUM_SRC = 4, SRC_W = 2, MAX_LEN = 2047, WDOG_CYC = 4096;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NUM_SRC-1:0] src_req = '0, src_valid = '0, src_eop = '0;
  logic [8*NUM_SRC-1:0] src_data = '0;
  logic pmm_ready = 1'b0, eop_shift = 1'b0, filter_trigger = 1'b0;
  logic [10:0] rule_id = '0;
  logic [NUM_SRC-1:0] src_grant, src_trunc;
  logic [7:0] payload_out;
  logic payload_valid, start_of_packet, end_of_packet, result_valid, busy, wdog_timeout;
  logic [SRC_W-1:0] result_src, cur_src;
  logic [10:0] result_rule;
  int n_cmp = 0, n_bad = 0, ptr = 0;
  logic exp_rv = 1'b0;
  logic [SRC_W-1:0] exp_rsrc = '0;
  logic [10:0] exp_rule = '0;
  always #5 clk = ~clk;
  payload_sched dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_data(src_data), .src_valid(src_valid),
    .src_eop(src_eop), .src_grant(src_grant), .src_trunc(src_trunc), .payload_out(payload_out),
    .payload_valid(payload_valid), .start_of_packet(start_of_packet), .end_of_packet(end_of_packet),
    .pmm_ready(pmm_ready), .eop_shift(eop_shift), .filter_trigger(filter_trigger), .rule_id(rule_id),
    .result_valid(result_valid), .result_src(result_src), .result_rule(result_rule),
    .cur_src(cur_src), .busy(busy), .wdog_timeout(wdog_timeout)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic chk_zero(input string t);
    chk({t, "_grant"}, src_grant, 0);
    chk({t, "_trunc"}, src_trunc, 0);
    chk({t, "_pout"}, payload_out, 0);
    chk({t, "_pvalid"}, payload_valid, 0);
    chk({t, "_sop"}, start_of_packet, 0);
    chk({t, "_eop"}, end_of_packet, 0);
    chk({t, "_rvalid"}, result_valid, 0);
    chk({t, "_rsrc"}, result_src, 0);
    chk({t, "_rrule"}, result_rule, 0);
    chk({t, "_cur_src"}, cur_src, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_wdog"}, wdog_timeout, 0);
  endtask
  // Reference arbitration: first requester at or after the model pointer, wrapping.
  function automatic int pick(input logic [NUM_SRC-1:0] req);
    for (int k = 0; k < NUM_SRC; k++) if (req[(ptr + k) % NUM_SRC]) return (ptr + k) % NUM_SRC;
    return 0;
  endfunction
  task automatic res_check();
    chk("result_valid", result_valid, exp_rv);
    if (exp_rv) begin
      chk("result_src", result_src, exp_rsrc);
      chk("result_rule", result_rule, exp_rule);
    end
  endtask
  task automatic res_drive(input bit owned, input int s, input bit force_trig);
    filter_trigger = force_trig || ($urandom_range(3) == 0);
    rule_id = force_trig ? 11'h123 : 11'($urandom);
    exp_rv = filter_trigger && owned;
    exp_rsrc = SRC_W'(s);
    exp_rule = rule_id;
  endtask
  // One packet exchange: request, stream (with lane noise and gaps), wait, eop_shift.
  task automatic packet(input logic [NUM_SRC-1:0] req, input int len, input bit noeop, input int base,
                        input int hold, input int abort_at, output int gs);
    int s, i, k, w, stall;
    bit done, pv, pe;
    logic [7:0] pb;
    logic [NUM_SRC-1:0] oh, v, e;
    logic [31:0] d;
    s = pick(req);
    oh = NUM_SRC'(1) << s;
    stall = $urandom_range(2);
    for (int c = 0; c < stall; c++) begin
      src_req = req; pmm_ready = 1'b0; eop_shift = 1'($urandom_range(1));
      res_drive(0, s, 0);
      @(negedge clk);
      res_check();
      chk("stall_grant", src_grant, 0);
      chk("stall_busy", busy, 0);
    end
    src_req = req; pmm_ready = 1'b1; eop_shift = 1'b0;
    res_drive(0, s, 0);
    @(negedge clk);
    res_check();
    gs = int'(cur_src);
    chk("grant", src_grant, oh);
    chk("cur_src", cur_src, s);
    chk("busy_grant", busy, 1);
    i = 0; k = 0; w = 0; done = 0;
    while (i < len) begin
      pv = $urandom_range(3) != 0;
      pe = pv && !noeop && (i == len - 1);
      pb = base >= 0 ? 8'(base + i) : 8'($urandom);
      v = NUM_SRC'($urandom); e = NUM_SRC'($urandom); d = $urandom;
      v[s] = pv; e[s] = pe; d[8*s +: 8] = pb;
      src_valid = v; src_eop = e; src_data = d;
      if (pv) i++;
      src_req = ($urandom_range(3) == 0) ? '0 : req;
      pmm_ready = 1'($urandom_range(1));
      eop_shift = !done && ($urandom_range(7) == 0);
      res_drive(1, s, 0);
      @(negedge clk);
      res_check();
      if (done) w++;
      if (pv && !done) begin
        chk("pvalid", payload_valid, 1);
        chk("byte", payload_out, pb);
        chk("sop", start_of_packet, k == 0);
        chk("eop", end_of_packet, pe || k == MAX_LEN - 1);
        chk("trunc", src_trunc, (!pe && k == MAX_LEN - 1) ? oh : '0);
        done = pe || k == MAX_LEN - 1;
        k++;
      end else begin
        chk("pvalid_idle", payload_valid, 0);
        chk("trunc_idle", src_trunc, 0);
      end
      chk("grant_stream", src_grant, done ? '0 : oh);
      chk("busy_stream", busy, 1);
      if (abort_at > 0 && k == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        src_valid = '0; src_eop = '0; src_req = '0; filter_trigger = 1'b0; eop_shift = 1'b0;
        @(negedge clk);
        chk_zero("in_rst");
        rst_n = 1'b1; ptr = 0; exp_rv = 1'b0;
        return;
      end
    end
    src_valid = '0; src_eop = '0; src_data = '0;
    for (int c = 0; c < hold; c++) begin
      eop_shift = 1'b0; pmm_ready = 1'($urandom_range(1)); src_req = NUM_SRC'($urandom);
      res_drive(1, s, c == 0);
      @(negedge clk);
      res_check();
      w++;
`ifdef PAYLOAD_SCHED_WATCHDOG_EN
      if (w == WDOG_CYC) begin
        chk("wdog_pulse", wdog_timeout, 1);
        chk("wdog_idle", busy, 0);
        ptr = (s + 1) % NUM_SRC;
        src_req = '0; pmm_ready = 1'b0;
        return;
      end
`endif
      chk("wdog_quiet", wdog_timeout, 0);
      chk("busy_wait", busy, 1);
      chk("grant_wait", src_grant, 0);
      chk("pvalid_wait", payload_valid, 0);
    end
    eop_shift = 1'b1; src_req = '0; pmm_ready = 1'b0;
    res_drive(1, s, 0);
    @(negedge clk);
    res_check();
    chk("busy_after_shift", busy, 0);
    chk("grant_after_shift", src_grant, 0);
    eop_shift = 1'b0;
    ptr = (s + 1) % NUM_SRC;
  endtask
  initial begin
    int gs;
    logic [NUM_SRC-1:0] rq;
    #12 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    packet(4'b0001, 5, 0, 'h41, 3, 0, gs);
    chk("single_src", gs, 0);
    packet(4'b1000, 3, 0, -1, 2, 0, gs);
    chk("src3_solo", gs, 3);
    for (int r = 0; r < 12; r++) begin
      packet(4'b1111, $urandom_range(1, 12), 0, -1, $urandom_range(1, 4), 0, gs);
      chk("rr_order", gs, r % 4);
    end
    packet(4'b0100, 2050, 1, -1, 2, 0, gs);
    chk("trunc_src", gs, 2);
    packet(4'b0100, 2047, 0, -1, 1, 0, gs);
    packet(4'b0100, 2048, 0, -1, 1, 0, gs);
    packet(4'b0100, 30, 0, -1, 1, 10, gs);
    packet(4'b1110, 4, 0, -1, 2, 0, gs);
    chk("rst_rr_ptr", gs, 1);
    packet(4'b1000, 6, 0, -1, 3, 0, gs);
    chk("rule_src", gs, 3);
    packet(4'b1111, 4, 0, -1, WDOG_CYC + 8, 0, gs);
    chk("wdog_src", gs, 0);
    for (int r = 0; r < 40; r++) begin
      rq = NUM_SRC'($urandom_range(1, 15));
      packet(rq, $urandom_range(1, 24), 0, -1, $urandom_range(1, 5), 0, gs);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
